// File: rtl/demux_stream.sv
// Registered, flow-controlled 1-to-N stream demultiplexer with a one-beat holding register per channel.
// Optional saturating drop counter enabled by defining DEMUX_STREAM_ERR_CNT_EN.
module demux_stream #(
    parameter int NUM_OUTPUTS = 5,
    parameter int DATA_WIDTH  = 8,
    localparam int SEL_WIDTH  = $clog2(NUM_OUTPUTS)
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [DATA_WIDTH-1:0]             i_data_bus,
    input  logic [SEL_WIDTH-1:0]              i_select,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_output,
    output logic [NUM_OUTPUTS-1:0]            o_valid,
    input  logic [NUM_OUTPUTS-1:0]            i_ready,
    output logic                              o_drop,
    output logic [7:0]                        o_err_count
);

    localparam logic [SEL_WIDTH:0] NUM_OUT_W = (SEL_WIDTH + 1)'(NUM_OUTPUTS);

    logic [NUM_OUTPUTS-1:0]            r_valid;
    logic [NUM_OUTPUTS*DATA_WIDTH-1:0] r_data;
    logic                              r_drop;

    logic [NUM_OUTPUTS-1:0] w_hit;
    logic [NUM_OUTPUTS-1:0] w_load;
    logic                   w_in_range;
    logic                   w_accept;
    logic                   w_drop_next;

    // Decode the select into a one-hot channel hit vector.
    always_comb begin
        w_hit = {NUM_OUTPUTS{1'b0}};
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (i_select == SEL_WIDTH'(k)) begin
                w_hit[k] = 1'b1;
            end else begin
                w_hit[k] = 1'b0;
            end
        end
    end

    // Handshake: out-of-range beats are always swallowed; in-range ones need room on the target.
    always_comb begin
        w_in_range = ({1'b0, i_select} < NUM_OUT_W);
        if (w_in_range) begin
            o_ready = |(w_hit & (~r_valid | i_ready));
        end else begin
            o_ready = 1'b1;
        end
        w_accept    = i_valid & o_ready;
        w_drop_next = w_accept & ~w_in_range;
        if (w_accept & w_in_range) begin
            w_load = w_hit;
        end else begin
            w_load = {NUM_OUTPUTS{1'b0}};
        end
    end

    // Per-channel holding registers: a load wins over a drain so drain+load keeps the slot full.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= {NUM_OUTPUTS{1'b0}};
            r_data  <= {(NUM_OUTPUTS*DATA_WIDTH){1'b0}};
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (w_load[k]) begin
                    r_valid[k]                          <= 1'b1;
                    r_data[k*DATA_WIDTH +: DATA_WIDTH]  <= i_data_bus;
                end else if (r_valid[k] & i_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end else begin
                    r_valid[k] <= r_valid[k];
                end
            end
        end
    end

    // One-cycle drop flag for each discarded beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop_next;
        end
    end

`ifdef DEMUX_STREAM_ERR_CNT_EN
    logic [7:0] r_err_count;

    // Saturating drop counter, updated together with the drop flag so both appear in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_count <= 8'h00;
        end else if (w_drop_next && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign o_err_count = r_err_count;
`else
    assign o_err_count = 8'h00;
`endif

    assign o_valid  = r_valid;
    assign o_output = r_data;
    assign o_drop   = r_drop;

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus randomized traffic against a
// behavioural channel model compared every cycle.
module tb_demux_stream;

    localparam int N = 5;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   data_in;
    logic [2:0]     sel;
    logic           vin;
    logic           rdy_out;
    logic [N*W-1:0] dout;
    logic [N-1:0]   vout;
    logic [N-1:0]   rdy_in;
    logic           drop;
    logic [7:0]     errc;

    demux_stream #(.NUM_OUTPUTS(N), .DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_bus(data_in), .i_select(sel),
        .i_valid(vin), .o_ready(rdy_out), .o_output(dout), .o_valid(vout),
        .i_ready(rdy_in), .o_drop(drop), .o_err_count(errc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model
    logic         m_full [N];
    logic [W-1:0] m_data [N];
    logic         m_drop;
    int           m_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_ready;

`ifdef DEMUX_STREAM_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_drop = 1'b0;
        m_err  = 0;
    endtask

    function automatic logic model_ready();
        if (int'(sel) >= N) return 1'b1;
        return !m_full[sel] || rdy_in[sel];
    endfunction

    task automatic compare_all();
        logic [N*W-1:0] exp_out;
        logic [N-1:0]   exp_v;
        for (int k = 0; k < N; k++) begin
            exp_out[k*W +: W] = m_data[k];
            exp_v[k]          = m_full[k];
        end
        chk("cyc_valid", 64'(vout), 64'(exp_v));
        chk("cyc_output", 64'(dout), 64'(exp_out));
        chk("cyc_drop", 64'(drop), 64'(m_drop));
        chk("cyc_err", 64'(errc), CNT_EN ? 64'(m_err) : 64'd0);
        chk("cyc_ready", 64'(rdy_out), 64'(model_ready()));
    endtask

    // Apply inputs, check at the falling edge, then advance the model with the rising edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [W-1:0] d, input logic [N-1:0] r);
        logic acc;
        vin = v; sel = s; data_in = d; rdy_in = r;
        @(negedge clk);
        compare_all();
        last_ready = rdy_out;
        acc = v && model_ready();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (acc && int'(s) == k) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (m_full[k] && r[k]) begin
                m_full[k] = 1'b0;
            end
        end
        m_drop = acc && (int'(s) >= N);
        if (m_drop && m_err < 255) m_err++;
        #1;
    endtask

    initial begin
        logic         pv;
        logic [2:0]   ps;
        logic [W-1:0] pd;
        logic         stalled;

        rst_n = 1'b0; vin = 1'b0; sel = 3'd0; data_in = 8'h00; rdy_in = 5'h1F;
        model_reset();
        @(posedge clk); #1;
        chk("rst_valid", 64'(vout), 64'd0);
        chk("rst_output", 64'(dout), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_err", 64'(errc), 64'd0);
        rst_n = 1'b1;

        // routing
        step(1'b1, 3'd0, 8'hAA, 5'h1F);
        chk("route0_valid", 64'(vout), 64'h01);
        step(1'b1, 3'd1, 8'hAA, 5'h1F);
        chk("route1_valid", 64'(vout), 64'h02);
        step(1'b1, 3'd2, 8'hAA, 5'h1F);
        chk("route2_valid", 64'(vout), 64'h04);
        chk("route_slices", 64'(dout[23:0]), 64'hAAAAAA);
        chk("route_drop", 64'(drop), 64'd0);
        step(1'b0, 3'd0, 8'h00, 5'h1F);
        chk("route_idle_valid", 64'(vout), 64'd0);

        // out-of-range select
        step(1'b1, 3'd7, 8'hAA, 5'h1F);
        chk("oor_ready", 64'(last_ready), 64'd1);
        chk("oor_valid", 64'(vout), 64'd0);
        chk("oor_drop", 64'(drop), 64'd1);
        chk("oor_err", 64'(errc), CNT_EN ? 64'd1 : 64'd0);
        step(1'b0, 3'd0, 8'h00, 5'h1F);
        chk("oor_drop_end", 64'(drop), 64'd0);

        // backpressure and isolation
        step(1'b1, 3'd1, 8'h11, 5'h1D);
        chk("bp_first", 64'(dout[15:8]), 64'h11);
        step(1'b1, 3'd3, 8'h33, 5'h1D);
        chk("iso_ready", 64'(last_ready), 64'd1);
        chk("iso_valid3", 64'(vout[3]), 64'd1);
        step(1'b1, 3'd1, 8'h22, 5'h1D);
        chk("bp_ready_low", 64'(last_ready), 64'd0);
        chk("bp_hold", 64'(dout[15:8]), 64'h11);
        step(1'b1, 3'd1, 8'h22, 5'h1F);
        chk("bp_release_ready", 64'(last_ready), 64'd1);
        chk("bp_no_gap", 64'(vout[1]), 64'd1);
        chk("bp_new_data", 64'(dout[15:8]), 64'h22);

        // saturation
        for (int i = 0; i < 260; i++) step(1'b1, 3'd7, 8'($urandom), 5'h1F);
        chk("sat_err", 64'(errc), CNT_EN ? 64'd255 : 64'd0);
        step(1'b1, 3'd7, 8'h01, 5'h1F);
        chk("sat_hold", 64'(errc), CNT_EN ? 64'd255 : 64'd0);

        // reset mid-stream
        step(1'b1, 3'd0, 8'h55, 5'h00);
        step(1'b1, 3'd3, 8'h66, 5'h00);
        chk("pre_rst_valid", 64'(vout), 64'h09);
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vout), 64'd0);
        chk("mid_rst_output", 64'(dout), 64'd0);
        chk("mid_rst_err", 64'(errc), 64'd0);
        model_reset();
        rst_n = 1'b1;
        step(1'b1, 3'd0, 8'h77, 5'h1F);
        chk("post_rst_valid", 64'(vout), 64'h01);
        chk("post_rst_data", 64'(dout[7:0]), 64'h77);

        // randomized traffic; producer holds the beat while stalled
        stalled = 1'b0; pv = 1'b0; ps = 3'd0; pd = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if (!stalled) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 3'($urandom_range(0, 7));
                pd = 8'($urandom);
            end
            rdy_in = r; sel = ps;
            stalled = pv && !model_ready();
            step(pv, ps, pd, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
